// File: rtl/ad_spi_gen_if.sv
// Control and SPI pin bundle between the ADC frame generator and its consumers.
interface ad_spi_gen_if;
  logic en;
  logic trig;
  logic cs_n;
  logic sclk;
  logic busy;
  logic frame_done;
  logic ovr;

  // Generator side: takes start controls, drives the SPI pins and status.
  modport master (
    input  en,
    input  trig,
    output cs_n,
    output sclk,
    output busy,
    output frame_done,
    output ovr
  );

  // Consumer side: drives start controls, observes pins and status.
  modport slave (
    output en,
    output trig,
    input  cs_n,
    input  sclk,
    input  busy,
    input  frame_done,
    input  ovr
  );
endinterface

// File: rtl/ad_spi_gen.sv
// SPI frame generator for the serial ADC: free-running or single-shot cs_n/sclk frames.
module ad_spi_gen #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned NBITS         = 16,
  parameter int unsigned SAMPLE_PERIOD = 200,
  parameter int unsigned T_SETUP       = 2,
  parameter int unsigned T_QUIET       = 4
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  ad_spi_gen_if.master  spi_io
);

  // One phase counter serves the divider, setup/hold and quiet intervals.
  localparam int unsigned CntMax0 = (CLK_DIV > T_SETUP) ? CLK_DIV : T_SETUP;
  localparam int unsigned CntMax  = (CntMax0 > T_QUIET) ? CntMax0 : T_QUIET;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned BitW    = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned PerW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] QuietLast = CntW'(T_QUIET - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(NBITS - 1);
  localparam logic [PerW-1:0] PerLast   = PerW'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StQuiet} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [BitW-1:0] bit_q;
  logic [PerW-1:0] per_q, per_d;
  logic            cs_n_q, sclk_q, busy_q, done_q;
  logic            tick, req;

  // Period counter: parked at zero while disabled so enabling fires a tick at once.
  always_comb begin
    per_d = per_q;
    if (!spi_io.en || per_q == PerLast) begin
      per_d = '0;
    end else begin
      per_d = per_q + 1'b1;
    end
  end

  // Period counter register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      per_q <= '0;
    end else begin
      per_q <= per_d;
    end
  end

  assign tick = spi_io.en && (per_q == '0);
  assign req  = tick || spi_io.trig;

  // Frame FSM with registered pins; sclk and cs_n never toggle in the same cycle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            state_q <= StSetup;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            state_q <= StShift;
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StShift: begin
          if (cnt_q == DivLast) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bit_q == BitLast) begin
              // sclk stays high through hold so the last rise is the only one.
              state_q <= StHold;
            end else begin
              bit_q  <= bit_q + 1'b1;
              sclk_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == SetupLast) begin
            state_q <= StQuiet;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StQuiet: begin
          if (cnt_q == QuietLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi_io.cs_n       = cs_n_q;
  assign spi_io.sclk       = sclk_q;
  assign spi_io.busy       = busy_q;
  assign spi_io.frame_done = done_q;
  // Dropped requests are flagged in the cycle they arrive, including the last quiet cycle.
  assign spi_io.ovr        = req && (state_q != StIdle);

endmodule

// File: tb/tb_ad_spi_gen.sv
// Bench for ad_spi_gen: directed scenarios plus random en/trig against a frame-window model.
module tb_ad_spi_gen;
  localparam int ClkDiv  = 4;
  localparam int NBits   = 16;
  localparam int Period  = 200;
  localparam int TSetup  = 2;
  localparam int TQuiet  = 4;
  localparam int CsLen   = 2 * TSetup + 2 * ClkDiv * NBits;
  localparam int BusyLen = CsLen + TQuiet;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b1;

  ad_spi_gen_if bus ();
  ad_spi_gen_if bus2 ();

  ad_spi_gen dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .spi_io  (bus)
  );

  ad_spi_gen #(
    .SAMPLE_PERIOD (100)
  ) dut2 (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .spi_io  (bus2)
  );

  always #5 clk_sys = ~clk_sys;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: start cycle of the current frame and consecutive-enable run length.
  int cyc, run, start;
  bit have;

  // Observed statistics since the last reset.
  int   rises, low_cnt, fd_cnt, ovr_cnt;
  int   falls[$];
  logic prev_sclk, prev_cs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset;
    @(negedge clk_sys);
    bus.en   = 1'b0;
    bus.trig = 1'b0;
    bus2.en  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_cs_n", bus.cs_n, 1);
    check_eq("rst_sclk", bus.sclk, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.frame_done, 0);
    check_eq("rst_ovr", bus.ovr, 0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n     = 1'b1;
    cyc       = 0;
    run       = 0;
    have      = 0;
    start     = 0;
    rises     = 0;
    low_cnt   = 0;
    fd_cnt    = 0;
    ovr_cnt   = 0;
    falls.delete();
    prev_sclk = 1'b1;
    prev_cs   = 1'b1;
  endtask

  task automatic step(input logic en_v, input logic trig_v);
    bit   tick, req, act;
    int   rel;
    logic exp_cs, exp_sclk;
    @(negedge clk_sys);
    bus.en   = en_v;
    bus.trig = trig_v;
    #1;
    tick   = en_v && (run % Period == 0);
    req    = tick || trig_v;
    act    = have && cyc >= start && cyc < start + BusyLen;
    exp_cs = !(have && cyc >= start && cyc < start + CsLen);
    rel    = cyc - start - TSetup;
    exp_sclk = 1'b1;
    if (have && rel >= 0 && rel < 2 * ClkDiv * NBits) exp_sclk = (rel % (2 * ClkDiv)) >= ClkDiv;
    check_eq("cs_n", bus.cs_n, exp_cs);
    check_eq("sclk", bus.sclk, exp_sclk);
    check_eq("busy", bus.busy, act);
    check_eq("frame_done", bus.frame_done, have && cyc == start + CsLen);
    check_eq("ovr", bus.ovr, req && act);
    if (bus.cs_n === 1'b0 && prev_sclk === 1'b0 && bus.sclk === 1'b1) rises++;
    if (bus.cs_n === 1'b0) low_cnt++;
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.ovr === 1'b1) ovr_cnt++;
    if (prev_cs === 1'b1 && bus.cs_n === 1'b0) falls.push_back(cyc);
    prev_sclk = bus.sclk;
    prev_cs   = bus.cs_n;
    if (req && !act) begin
      have  = 1;
      start = cyc + 1;
    end
    run = en_v ? run + 1 : 0;
    cyc++;
  endtask

  initial begin
    logic e;
    bus.en   = 1'b0;
    bus.trig = 1'b0;
    bus2.en  = 1'b0;
    bus2.trig = 1'b0;

    // Free-running frames at the default period, then en dropped mid-frame.
    apply_reset;
    repeat (200) step(1'b1, 1'b0);
    check_eq("t1_rises", rises, NBits);
    check_eq("t1_low", low_cnt, CsLen);
    check_eq("t1_done", fd_cnt, 1);
    repeat (220) step(1'b1, 1'b0);
    repeat (300) step(1'b0, 1'b0);
    check_eq("t1_frames", falls.size(), 3);
    if (falls.size() == 3) begin
      check_eq("t1_fall0", falls[0], 1);
      check_eq("t1_fall1", falls[1], 201);
      check_eq("t1_fall2", falls[2], 401);
    end
    check_eq("t1_done_all", fd_cnt, 3);

    // Single trig at cycle 10.
    apply_reset;
    repeat (10) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (289) step(1'b0, 1'b0);
    check_eq("t2_frames", falls.size(), 1);
    if (falls.size() == 1) check_eq("t2_fall", falls[0], 11);
    check_eq("t2_low", low_cnt, CsLen);

    // Second trig during a frame is dropped.
    apply_reset;
    repeat (10) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (39) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (250) step(1'b0, 1'b0);
    check_eq("t3_ovr", ovr_cnt, 1);
    check_eq("t3_frames", falls.size(), 1);

    // trig on the last busy cycle is dropped, one cycle later it is taken.
    apply_reset;
    repeat (10) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (135) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (200) step(1'b0, 1'b0);
    check_eq("tb_ovr", ovr_cnt, 1);
    check_eq("tb_frames", falls.size(), 2);
    if (falls.size() == 2) check_eq("tb_fall1", falls[1], 148);

    // tick and trig together start one frame without overrun.
    apply_reset;
    step(1'b1, 1'b1);
    repeat (150) step(1'b0, 1'b0);
    check_eq("tt_ovr", ovr_cnt, 0);
    check_eq("tt_frames", falls.size(), 1);

    // Reset during bit 7, then a clean frame.
    apply_reset;
    repeat (61) step(1'b1, 1'b0);
    check_eq("t5_pre_rises", rises, 7);
    apply_reset;
    repeat (150) step(1'b1, 1'b0);
    check_eq("t5_rises", rises, NBits);
    check_eq("t5_done", fd_cnt, 1);

    // Random en/trig traffic.
    apply_reset;
    e = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 249) == 0) e = ~e;
      step(e, $urandom_range(0, 39) == 0);
    end

    // Period shorter than busy time: alternate ticks overrun.
    apply_reset;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_sys);
      bus2.en = 1'b1;
      #1;
      check_eq("t4_cs_n", bus2.cs_n, !((c % 200) >= 1 && (c % 200) <= CsLen));
      check_eq("t4_ovr", bus2.ovr, (c % 200) == 100);
    end
    bus2.en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
